global_int_sequencer: RTL and testbench
=======================================

// Module: global_int_sequencer
// PURPOSE
//  Sequences global (external) interrupt assertions into the core under test.
//  Queues interrupt requests of {mask, delay, hold}, waits the programmed delay, then drives them.
//  Drives the global interrupt vector until every asserted bit is acknowledged or a hold timeout expires.
//  Sits between the interrupt stimulus source and the core's global interrupt inputs.
// PARAMETERS
//  NUM_INTS  64  width of the global interrupt vector
//  DEPTH     4   request FIFO entries (>=2, power of two)
//  DLY_W     16  width of the delay field
//  HOLD_W    16  width of the hold field
// PORTS
//  clock          in   1                  single clock; all logic on posedge
//  reset          in   1                  synchronous, active-high
//  req_valid      in   1                  request offered
//  req_ready      out  1                  FIFO not full; request accepted when valid&&ready
//  req_mask       in   NUM_INTS           interrupt bits to assert
//  req_delay      in   DLY_W              idle cycles before assertion
//  req_hold       in   HOLD_W             max assertion cycles; 0 = hold until fully acked
//  int_ack        in   NUM_INTS           per-bit acknowledge from core/monitor
//  global_int     out  NUM_INTS           registered interrupt vector to core
//  busy           out  1                  state!=IDLE or FIFO non-empty
//  done_pulse     out  1                  1-cycle: request completed by acks
//  timeout_pulse  out  1                  1-cycle: request ended by hold expiry
//  pending_count  out  $clog2(DEPTH+1)    entries in FIFO (excludes active request)
// BEHAVIOUR
//  Reset: global_int=0, done_pulse=0, timeout_pulse=0, pending_count=0, busy=0, req_ready=1.
//   FIFO flushed, FSM=IDLE, counters cleared. Reset mid-request aborts it; no pulse is issued.
//  FIFO: req_ready = !full (no same-cycle pop bypass). Push and pop in the same cycle are both legal.
//   pending_count updates the cycle after push/pop.
//  FSM IDLE: FIFO non-empty -> pop head, dly_cnt<=delay, rem<=mask, hold_cnt<=hold -> WAIT.
//  FSM WAIT: dly_cnt==0 -> DRIVE and global_int<=rem; else dly_cnt--.
//  Latency: request accepted in cycle T (FIFO empty, IDLE).
//   global_int first high in cycle T+3+delay.
//  FSM DRIVE, evaluated each cycle with nxt = rem & ~int_ack:
//   nxt==0 -> global_int<=0, done_pulse<=1, -> IDLE.
//   else if hold!=0 && hold_cnt==1 -> global_int<=0, timeout_pulse<=1, -> IDLE.
//   else rem<=nxt, global_int<=nxt, hold_cnt-- (when hold!=0).
//  Result: with no acks, global_int stays high exactly hold cycles.
//  Acks take effect the cycle after they are sampled. Ack bits outside rem are ignored.
//  Simultaneous final ack and hold expiry: done wins (done_pulse only).
//  mask==0: reaches DRIVE with global_int=0 and completes at once -> done_pulse next cycle.
//  Back-to-back: from IDLE the next entry pops the cycle after done/timeout. global_int is 0 for >=2 cycles between requests.
//  Pulses are never both high and never high for more than one cycle.
//  Counters wrap never: dly_cnt and hold_cnt only decrement from loaded value, stop at 0/1.
// TESTING
//  T1: mask=0x1, delay=0, hold=0; int_ack[0]=1 three cycles after assertion
//      -> global_int=0x1 from T+3, 0 after ack, done_pulse one cycle.
//  T2: mask=0x8000_0000_0000_0003, delay=5; ack bit0, then bit1, then bit63 on separate cycles
//      -> bits drop individually; first assert at T+8; done_pulse after bit63 ack.
//  T3: mask=0xF0, hold=4, no acks; second request queued
//      -> global_int=0xF0 exactly 4 cycles, timeout_pulse; second request starts from IDLE next cycle.
//  T4: push 5 requests back-to-back while the first is in WAIT (delay=100)
//      -> pending_count reaches 4, req_ready=0; 5th held until a pop.
//  T5: hold=3, final ack arrives in the hold_cnt==1 cycle -> done_pulse=1, timeout_pulse=0.
//  T6: reset during DRIVE with 2 entries queued
//      -> next cycle global_int=0, pending_count=0, busy=0, no pulses.

Source files
------------

// File: rtl/global_int_sequencer_if.sv
// Request/interrupt bus between the stimulus source (master) and the
// global interrupt sequencer (slave).
interface global_int_sequencer_if #(
    parameter int unsigned NUM_INTS = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DLY_W    = 16,
    parameter int unsigned HOLD_W   = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                req_valid;
    logic                req_ready;
    logic [NUM_INTS-1:0] req_mask;
    logic [DLY_W-1:0]    req_delay;
    logic [HOLD_W-1:0]   req_hold;
    logic [NUM_INTS-1:0] int_ack;
    logic [NUM_INTS-1:0] global_int;
    logic                busy;
    logic                done_pulse;
    logic                timeout_pulse;
    logic [CNT_W-1:0]    pending_count;

    modport master (
        output req_valid, req_mask, req_delay, req_hold, int_ack,
        input  req_ready, global_int, busy, done_pulse, timeout_pulse, pending_count
    );

    modport slave (
        input  req_valid, req_mask, req_delay, req_hold, int_ack,
        output req_ready, global_int, busy, done_pulse, timeout_pulse, pending_count
    );
endinterface

// File: rtl/global_int_sequencer.sv
// Queues {mask, delay, hold} interrupt requests, waits the delay, then drives
// the global interrupt vector until fully acknowledged or the hold expires.
module global_int_sequencer #(
    parameter int unsigned NUM_INTS = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DLY_W    = 16,
    parameter int unsigned HOLD_W   = 16
) (
    input logic                   clock,
    input logic                   reset,
    global_int_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;

    logic [NUM_INTS-1:0] mask_mem [DEPTH];
    logic [DLY_W-1:0]    dly_mem  [DEPTH];
    logic [HOLD_W-1:0]   hold_mem [DEPTH];

    logic [PTR_W-1:0]    wp, rp;
    logic [CNT_W-1:0]    count;
    state_t              state;
    logic [DLY_W-1:0]    dly_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hold_en;
    logic [NUM_INTS-1:0] rem;
    logic [NUM_INTS-1:0] gint;
    logic                done_r, timeout_r;

    logic                full, empty, push, pop;
    logic [NUM_INTS-1:0] nxt;

    always_comb begin
        full  = (count == CNT_W'(DEPTH));
        empty = (count == '0);
        // No pop bypass: a full FIFO refuses a push even while popping.
        push  = bus.req_valid && !full;
        pop   = (state == S_IDLE) && !empty;
        nxt   = rem & ~bus.int_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            state     <= S_IDLE;
            dly_cnt   <= '0;
            hold_cnt  <= '0;
            hold_en   <= 1'b0;
            rem       <= '0;
            gint      <= '0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;

            if (push) begin
                mask_mem[wp] <= bus.req_mask;
                dly_mem[wp]  <= bus.req_delay;
                hold_mem[wp] <= bus.req_hold;
                wp           <= wp + PTR_W'(1);
            end
            if (pop) begin
                rp <= rp + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        rem      <= mask_mem[rp];
                        dly_cnt  <= dly_mem[rp];
                        hold_cnt <= hold_mem[rp];
                        hold_en  <= (hold_mem[rp] != '0);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dly_cnt == '0) begin
                        gint  <= rem;
                        state <= S_DRIVE;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                S_DRIVE: begin
                    // Completion by acks is tested first so it wins over hold expiry.
                    if (nxt == '0) begin
                        gint   <= '0;
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end else if (hold_en && hold_cnt == HOLD_W'(1)) begin
                        gint      <= '0;
                        timeout_r <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        rem  <= nxt;
                        gint <= nxt;
                        if (hold_en) begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready     = !full;
        bus.global_int    = gint;
        bus.busy          = (state != S_IDLE) || !empty;
        bus.done_pulse    = done_r;
        bus.timeout_pulse = timeout_r;
        bus.pending_count = count;
    end
endmodule

// File: tb/tb_global_int_sequencer.sv
// Self-checking bench for global_int_sequencer: directed timing checks plus a
// scoreboard of per-request outcomes checked whenever a completion pulse fires.
module tb_global_int_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    global_int_sequencer_if #(.NUM_INTS(64), .DEPTH(4), .DLY_W(16), .HOLD_W(16)) bus ();

    global_int_sequencer #(.NUM_INTS(64), .DEPTH(4), .DLY_W(16), .HOLD_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_to;
        logic [63:0] vec;
        int          dur;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Offer a request from the current negedge, holding valid until accepted.
    task automatic push_req(input logic [63:0] m, input logic [15:0] d, input logic [15:0] h,
                            input logic is_to, input int dur, output int waited);
        exp_t e;
        logic acc;
        e.is_to = is_to;
        e.vec   = m;
        e.dur   = dur;
        sb.push_back(e);
        bus.req_mask  = m;
        bus.req_delay = d;
        bus.req_hold  = h;
        bus.req_valid = 1'b1;
        acc    = 1'b0;
        waited = 0;
        while (!acc && waited < 400) begin
            acc = bus.req_ready;
            @(negedge clock);
            if (!acc) waited++;
        end
        bus.req_valid = 1'b0;
        if (!acc) check_val("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((bus.busy || bus.global_int != '0) && n < 600) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, {63'd0, bus.busy}, 64'd0);
        tick(2);
    endtask

    // Completion monitor: tracks the asserted vector and its duration per request.
    logic [63:0] cur_vec = '0;
    int          cur_dur = 0;
    logic        prev_pulse = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            cur_vec    = '0;
            cur_dur    = 0;
            prev_pulse = 1'b0;
        end else begin
            if (bus.global_int != '0) begin
                if (cur_dur == 0) cur_vec = bus.global_int;
                cur_dur++;
            end
            if (bus.done_pulse || bus.timeout_pulse) begin
                exp_t e;
                check_val("pulse_excl", {63'd0, bus.done_pulse & bus.timeout_pulse}, 64'd0);
                check_val("pulse_len", {63'd0, prev_pulse}, 64'd0);
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("sb_kind", {63'd0, bus.timeout_pulse}, {63'd0, e.is_to});
                    check_val("sb_vec", cur_vec, e.vec);
                    check_val("sb_dur", 64'(cur_dur), 64'(e.dur));
                end
                cur_vec = '0;
                cur_dur = 0;
            end
            prev_pulse = bus.done_pulse | bus.timeout_pulse;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.req_valid = 1'b0;
        bus.req_mask  = '0;
        bus.req_delay = '0;
        bus.req_hold  = '0;
        bus.int_ack   = '0;

        tick(3);
        reset = 1'b0;
        check_val("rst_gint", bus.global_int, 64'd0);
        check_val("rst_pending", 64'(bus.pending_count), 64'd0);
        check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
        check_val("rst_ready", {63'd0, bus.req_ready}, 64'd1);
        check_val("rst_pulses", {62'd0, bus.done_pulse, bus.timeout_pulse}, 64'd0);

        // T1: single bit, acked three cycles after assertion.
        push_req(64'h1, 16'd0, 16'd0, 1'b0, 3, w);
        tick(1);
        check_val("t1_pre", bus.global_int, 64'd0);
        tick(1);
        check_val("t1_first", bus.global_int, 64'h1);
        tick(2);
        bus.int_ack = 64'h1;
        tick(1);
        bus.int_ack = '0;
        check_val("t1_drop", bus.global_int, 64'd0);
        check_val("t1_done", {63'd0, bus.done_pulse}, 64'd1);
        check_val("t1_busy", {63'd0, bus.busy}, 64'd0);
        wait_idle("t1_idle");

        // T2: delay 5, bits acked individually; bit4 ack is outside the mask.
        push_req(64'h8000_0000_0000_0003, 16'd5, 16'd0, 1'b0, 3, w);
        tick(6);
        check_val("t2_pre", bus.global_int, 64'd0);
        tick(1);
        check_val("t2_first", bus.global_int, 64'h8000_0000_0000_0003);
        bus.int_ack = 64'h1;
        tick(1);
        check_val("t2_ack0", bus.global_int, 64'h8000_0000_0000_0002);
        bus.int_ack = 64'h12;
        tick(1);
        check_val("t2_ack1", bus.global_int, 64'h8000_0000_0000_0000);
        bus.int_ack = 64'h8000_0000_0000_0000;
        tick(1);
        bus.int_ack = '0;
        check_val("t2_drop", bus.global_int, 64'd0);
        check_val("t2_done", {63'd0, bus.done_pulse}, 64'd1);
        wait_idle("t2_idle");

        // T3: hold expiry with a second request queued behind it.
        push_req(64'hF0, 16'd0, 16'd4, 1'b1, 4, w);
        push_req(64'h5, 16'd0, 16'd2, 1'b1, 2, w);
        tick(1);
        check_val("t3_first", bus.global_int, 64'hF0);
        check_val("t3_pending", 64'(bus.pending_count), 64'd1);
        tick(3);
        check_val("t3_last", bus.global_int, 64'hF0);
        tick(1);
        check_val("t3_drop", bus.global_int, 64'd0);
        check_val("t3_timeout", {63'd0, bus.timeout_pulse}, 64'd1);
        check_val("t3_nodone", {63'd0, bus.done_pulse}, 64'd0);
        tick(1);
        check_val("t3_gap", bus.global_int, 64'd0);
        check_val("t3_popped", 64'(bus.pending_count), 64'd0);
        tick(1);
        check_val("t3_second", bus.global_int, 64'h5);
        wait_idle("t3_idle");

        // T4: fill the FIFO while the first request sits in a long delay.
        push_req(64'h1, 16'd100, 16'd1, 1'b1, 1, w);
        tick(2);
        push_req(64'h2, 16'd0, 16'd1, 1'b1, 1, w);
        push_req(64'h0, 16'd0, 16'd3, 1'b0, 0, w);
        push_req(64'h4, 16'd0, 16'd2, 1'b1, 2, w);
        push_req(64'h8, 16'd0, 16'd1, 1'b1, 1, w);
        check_val("t4_full_count", 64'(bus.pending_count), 64'd4);
        check_val("t4_not_ready", {63'd0, bus.req_ready}, 64'd0);
        push_req(64'h10, 16'd0, 16'd1, 1'b1, 1, w);
        check_val("t4_held", {63'd0, w >= 90}, 64'd1);
        wait_idle("t4_idle");

        // T5: final ack lands in the last hold cycle; done wins.
        push_req(64'h3, 16'd0, 16'd3, 1'b0, 3, w);
        tick(2);
        bus.int_ack = 64'h1;
        tick(1);
        bus.int_ack = '0;
        check_val("t5_partial", bus.global_int, 64'h2);
        tick(1);
        bus.int_ack = 64'h2;
        tick(1);
        bus.int_ack = '0;
        check_val("t5_done", {63'd0, bus.done_pulse}, 64'd1);
        check_val("t5_notimeout", {63'd0, bus.timeout_pulse}, 64'd0);
        wait_idle("t5_idle");

        // T6: reset while driving with two entries queued.
        push_req(64'hFF, 16'd0, 16'd0, 1'b0, 0, w);
        push_req(64'h100, 16'd0, 16'd0, 1'b0, 0, w);
        push_req(64'h200, 16'd0, 16'd0, 1'b0, 0, w);
        check_val("t6_driving", bus.global_int, 64'hFF);
        check_val("t6_queued", 64'(bus.pending_count), 64'd2);
        reset = 1'b1;
        sb.delete();
        tick(1);
        check_val("t6_gint", bus.global_int, 64'd0);
        check_val("t6_pending", 64'(bus.pending_count), 64'd0);
        check_val("t6_busy", {63'd0, bus.busy}, 64'd0);
        check_val("t6_pulses", {62'd0, bus.done_pulse, bus.timeout_pulse}, 64'd0);
        reset = 1'b0;
        tick(6);
        check_val("t6_stays_idle", {63'd0, bus.busy | (bus.global_int != '0)}, 64'd0);

        check_val("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
